dram_uart_transmitter: RTL and testbench
========================================

# dram_uart_transmitter

Reads the result matrix from data memory (DRAM) after processing and serialises it to the PC over a UART line, 8N1, LSB first. Sits beside the processor in the top level; owns the DRAM address port while the state controller is in the transmit phase, and reports completion on `end_transmitting`. It is the sending counterpart of the PC-to-DRAM receive path and performs reads only.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (≥2)
- `READ_LATENCY`, 2, cycles from `mem_addr` change to valid `mem_data` (≥1)
- `START_ADDR`, 16'h0000, first DRAM byte address sent
- `BYTE_COUNT`, 16'd9, number of bytes sent (≥1)

Ports:
- `clock`  in  1  system clock (divided clock); the block's only clock
- `rst`  in  1  synchronous, active-high reset
- `begin_transmit`  in  1  debounced level; high starts a transfer
- `mem_data`  in  8  DRAM read data (`q`)
- `mem_addr`  out  16  DRAM read address
- `mem_rd`  out  1  high while a fetch is in progress
- `data_to_pc`  out  1  UART TX line, idle high
- `busy`  out  1  high from the start of the transfer until entry to DONE or IDLE
- `end_transmitting`  out  1  high in DONE

## Operation
- States: IDLE, FETCH, START, DATA, STOP, DONE.
- IDLE: `data_to_pc`=1. When `begin_transmit`=1 at a clock edge: load `mem_addr`=START_ADDR, byte index=0, go to FETCH.
- FETCH:
  - `mem_rd`=1 for READ_LATENCY cycles.
  - On the last cycle, latch `mem_data` into the shift register and go to START.
- START: `data_to_pc`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - Shift the register right after each bit.
  - Go to STOP after bit 7.
- STOP: `data_to_pc`=1 for CLKS_PER_BIT cycles. At the end:
  - if index = BYTE_COUNT−1: go to DONE if `begin_transmit`=1, otherwise to IDLE;
  - otherwise: increment index, set `mem_addr`=`mem_addr`+1 (mod 2^16, wraps 16'hFFFF→16'h0000), go to FETCH.
- DONE: `end_transmitting`=1. Stays in DONE until `begin_transmit`=0, then goes to IDLE. This prevents retrigger while the level is held.
- `begin_transmit` falling mid-transfer is ignored. The transfer completes, then the block goes directly to IDLE; `end_transmitting` is not asserted in that case.
- `mem_data` is sampled only on the last FETCH cycle.
- No write port exists; the top level keeps DRAM `wren`=0 while `busy`.
- Bit counter is 3 bits. Baud counter is $clog2(CLKS_PER_BIT) bits and counts from 0 to CLKS_PER_BIT−1. Index counter is 16 bits.

## Timing
- Reset values: state=IDLE, `data_to_pc`=1, `mem_addr`=START_ADDR, `mem_rd`=0, `busy`=0, `end_transmitting`=0, all counters 0.
- Reset at any point, including mid-byte, takes effect at the next edge. The TX line returns high immediately and no partial frame resumes.
- `begin_transmit` sampled high at edge k:
  - FETCH, `busy`=1 and `mem_rd`=1 from cycle k+1;
  - the start bit begins at cycle k+1+READ_LATENCY.
- Per byte: READ_LATENCY cycles (line high, extends the inter-byte gap) + 10×CLKS_PER_BIT cycles.
- Total transfer: BYTE_COUNT×(READ_LATENCY+10×CLKS_PER_BIT) cycles from the first FETCH cycle to DONE entry.
- Timing of the last byte's stop bit:
  - `end_transmitting` rises on the cycle after the last stop-bit cycle;
  - `busy` falls on that same cycle.

## Structure
- Shared package `comm_pkg`:
  - state enum (`tx_state_t`);
  - UART frame constants (`UART_DATA_BITS`=8, start/stop levels);
  - default CLKS_PER_BIT.
  - The receive path uses the same package.
- One sub-module, `uart_tx_serializer`:
  - covers the START/DATA/STOP byte engine with a `load`/`byte_in`/`done` handshake;
  - the parent keeps the address/fetch/index sequencing and the IDLE/DONE handling.

## Test plan
All scenarios use CLKS_PER_BIT=4 and READ_LATENCY=2 unless stated.
- BYTE_COUNT=3, START_ADDR=16'h0010, DRAM[0x10..0x12]={A5,3C,FF}, `begin_transmit` held high -> line decodes A5,3C,FF. `end_transmitting` rises exactly 3×42=126 cycles after the first FETCH cycle and stays high until `begin_transmit` is dropped.
- Single byte 8'h01 -> data_to_pc sequence 0,1,0,0,0,0,0,0,0,1, each bit 4 cycles wide. `mem_rd` is high for exactly 2 cycles beforehand.
- `rst` asserted during bit 3 of the second byte -> next edge: `data_to_pc`=1, `busy`=0, `mem_addr`=START_ADDR. A new `begin_transmit` restarts from byte 0.
- `begin_transmit` dropped during the first byte of 3 -> all 3 bytes are still sent, the block returns to IDLE, and `end_transmitting` stays 0.
- START_ADDR=16'hFFFF, BYTE_COUNT=2 -> reads addresses FFFF then 0000.
- Hold `begin_transmit` high in DONE for 100 cycles -> no second transfer. Drop it then raise it again -> a full second transfer runs.

Source files
------------

// File: rtl/comm_pkg.sv
// comm_pkg: definitions shared by the PC<->DRAM UART transmit and receive paths.
package comm_pkg;

  // Phases of a DRAM-to-PC transfer. The serializer walks START/DATA/STOP;
  // the transmitter top uses IDLE/FETCH/DONE and holds START while a frame is on the wire.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_FETCH,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  // 8N1 frame layout and line levels.
  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;
  localparam logic UART_IDLE_LEVEL  = 1'b1;

  // Default baud divider for the divided system clock.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: sends one 8N1 byte, LSB first, on a load pulse and
// pulses done during the final cycle of the stop bit.
module uart_tx_serializer
  import comm_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      load,
  input  logic [UART_DATA_BITS-1:0] byte_in,
  output logic                      tx,
  output logic                      done
);

  localparam int                BAUD_W    = counter_width(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // State register: reset drops any partial frame and parks the line idle.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next state: each line level lasts CLKS_PER_BIT cycles, data shifts right after every bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      TX_IDLE: begin
        if (load) begin
          state_d = TX_START;
          shift_d = byte_in;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      TX_START: begin
        if (baud_end) begin
          state_d = TX_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = TX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_end) begin
          state_d = TX_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Outputs: line level per phase, done on the last stop-bit cycle.
  always_comb begin
    tx   = UART_IDLE_LEVEL;
    done = 1'b0;
    case (state_q)
      TX_START: tx = UART_START_LEVEL;
      TX_DATA:  tx = shift_q[0];
      TX_STOP: begin
        tx   = UART_STOP_LEVEL;
        done = baud_end;
      end
      default:  tx = UART_IDLE_LEVEL;
    endcase
  end

endmodule

// File: rtl/dram_uart_transmitter.sv
// dram_uart_transmitter: streams BYTE_COUNT bytes from DRAM, starting at
// START_ADDR, to the PC over an 8N1 UART line and flags completion.
module dram_uart_transmitter
  import comm_pkg::*;
#(
  parameter int          CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int          READ_LATENCY = 2,
  parameter logic [15:0] START_ADDR   = 16'h0000,
  parameter logic [15:0] BYTE_COUNT   = 16'd9
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        begin_transmit,
  input  logic [7:0]  mem_data,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        data_to_pc,
  output logic        busy,
  output logic        end_transmitting
);

  localparam int                 FETCH_W    = counter_width(READ_LATENCY);
  localparam logic [FETCH_W-1:0] FETCH_LAST = FETCH_W'(READ_LATENCY - 1);
  localparam logic [15:0]        LAST_INDEX = BYTE_COUNT - 16'd1;

  // TX_START here means "a frame is on the wire"; the serializer owns START/DATA/STOP.
  tx_state_t          state_q, state_d;
  logic [15:0]        addr_q, addr_d;
  logic [15:0]        index_q, index_d;
  logic [FETCH_W-1:0] fetch_q, fetch_d;
  logic               ser_load;
  logic               ser_done;

  assign mem_addr = addr_q;

  // State register with synchronous reset back to an idle, unstarted transfer.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= TX_IDLE;
      addr_q  <= START_ADDR;
      index_q <= '0;
      fetch_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      index_q <= index_d;
      fetch_q <= fetch_d;
    end
  end

  // Next state: fetch each byte, hand it to the serializer, then advance or finish.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    index_d = index_q;
    fetch_d = fetch_q;
    case (state_q)
      TX_IDLE: begin
        if (begin_transmit) begin
          state_d = TX_FETCH;
          addr_d  = START_ADDR;
          index_d = '0;
          fetch_d = '0;
        end
      end
      TX_FETCH: begin
        if (fetch_q == FETCH_LAST) begin
          state_d = TX_START;
          fetch_d = '0;
        end else begin
          fetch_d = fetch_q + 1'b1;
        end
      end
      TX_START: begin
        if (ser_done) begin
          if (index_q == LAST_INDEX) begin
            state_d = begin_transmit ? TX_DONE : TX_IDLE;
          end else begin
            state_d = TX_FETCH;
            index_d = index_q + 16'd1;
            addr_d  = addr_q + 16'd1;
            fetch_d = '0;
          end
        end
      end
      TX_DONE: begin
        if (!begin_transmit) begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Outputs: status flags from the state, and the serializer load on the last fetch cycle.
  always_comb begin
    mem_rd           = (state_q == TX_FETCH);
    busy             = (state_q == TX_FETCH) || (state_q == TX_START);
    end_transmitting = (state_q == TX_DONE);
    ser_load         = (state_q == TX_FETCH) && (fetch_q == FETCH_LAST);
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clock  (clock),
    .rst    (rst),
    .load   (ser_load),
    .byte_in(mem_data),
    .tx     (data_to_pc),
    .done   (ser_done)
  );

endmodule

// File: tb/tb_dram_uart_transmitter.sv
// tb_dram_uart_transmitter: directed scenarios with a UART-decoding scoreboard
// for the main instance and a fetch-address scoreboard for both instances.
module tb_dram_uart_transmitter;

  localparam int CPB         = 4;
  localparam int RL          = 2;
  localparam int CYCLE_LIMIT = 2000;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        begin_transmit = 1'b0;
  logic        wrap_begin = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  wrap_mem_data = 8'h00;
  logic [15:0] mem_addr, wrap_mem_addr;
  logic        mem_rd, data_to_pc, busy, end_transmitting;
  logic        wrap_mem_rd, wrap_data_to_pc, wrap_busy, wrap_end;

  logic [7:0]  dram [0:65535];
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_addrs[$];
  logic [15:0] exp_wrap_addrs[$];

  int n_compared = 0;
  int n_mismatched = 0;

  // Clock generation
  always #5 clock = ~clock;

  // DRAM model: one registered read stage gives data in the second cycle after an address change
  always @(posedge clock) begin
    mem_data      <= dram[mem_addr];
    wrap_mem_data <= dram[wrap_mem_addr];
  end

  dram_uart_transmitter #(
    .CLKS_PER_BIT(CPB),
    .READ_LATENCY(RL),
    .START_ADDR  (16'h0010),
    .BYTE_COUNT  (16'd3)
  ) dut (
    .clock           (clock),
    .rst             (rst),
    .begin_transmit  (begin_transmit),
    .mem_data        (mem_data),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .data_to_pc      (data_to_pc),
    .busy            (busy),
    .end_transmitting(end_transmitting)
  );

  dram_uart_transmitter #(
    .CLKS_PER_BIT(CPB),
    .READ_LATENCY(RL),
    .START_ADDR  (16'hFFFF),
    .BYTE_COUNT  (16'd2)
  ) wrap_dut (
    .clock           (clock),
    .rst             (rst),
    .begin_transmit  (wrap_begin),
    .mem_data        (wrap_mem_data),
    .mem_addr        (wrap_mem_addr),
    .mem_rd          (wrap_mem_rd),
    .data_to_pc      (wrap_data_to_pc),
    .busy            (wrap_busy),
    .end_transmitting(wrap_end)
  );

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive begin_transmit just after a rising edge
  task automatic applyStimulus(input logic go);
    @(posedge clock);
    #1;
    begin_transmit = go;
  endtask

  // Queue the expected bytes and fetch addresses of one three-byte transfer
  task automatic pushMainTransfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_bytes.push_back(b0);
    exp_bytes.push_back(b1);
    exp_bytes.push_back(b2);
    exp_addrs.push_back(16'h0010);
    exp_addrs.push_back(16'h0011);
    exp_addrs.push_back(16'h0012);
  endtask

  // Count cycles until the main instance drops busy, bounded
  task automatic waitBusyLow(output int cycles);
    cycles = 0;
    while (busy && cycles < CYCLE_LIMIT) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  // Byte monitor: decodes 8N1 frames on data_to_pc and scores them against exp_bytes
  initial begin : byte_monitor
    logic        line_prev;
    logic [39:0] samples;
    logic [9:0]  frame;
    logic        shape_ok;
    logic        aborted;
    line_prev = 1'b1;
    forever begin
      @(negedge clock);
      if (!rst && line_prev && data_to_pc == 1'b0) begin
        samples    = '0;
        samples[0] = data_to_pc;
        aborted    = 1'b0;
        for (int j = 1; j < 40 && !aborted; j++) begin
          @(negedge clock);
          if (rst) aborted = 1'b1;
          else     samples[j] = data_to_pc;
        end
        if (!aborted) begin
          shape_ok = 1'b1;
          for (int b = 0; b < 10; b++) begin
            frame[b] = samples[4*b];
            for (int s = 1; s < 4; s++) begin
              if (samples[4*b+s] != frame[b]) shape_ok = 1'b0;
            end
          end
          if (frame[0] != 1'b0 || frame[9] != 1'b1) shape_ok = 1'b0;
          checkOutput("frame shape", 64'(shape_ok), 64'd1);
          if (exp_bytes.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected byte: actual=%0h expected=none", frame[8:1]);
          end else begin
            checkOutput("tx byte", 64'(frame[8:1]), 64'(exp_bytes.pop_front()));
          end
        end
      end
      line_prev = data_to_pc;
    end
  end

  // Fetch monitor: checks mem_addr at the start of every fetch of both instances
  initial begin : fetch_monitor
    logic rd_prev;
    logic wrap_rd_prev;
    rd_prev      = 1'b0;
    wrap_rd_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!rst && mem_rd && !rd_prev) begin
        if (exp_addrs.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected fetch: actual=%0h expected=none", mem_addr);
        end else begin
          checkOutput("fetch address", 64'(mem_addr), 64'(exp_addrs.pop_front()));
        end
      end
      if (!rst && wrap_mem_rd && !wrap_rd_prev) begin
        if (exp_wrap_addrs.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected wrap fetch: actual=%0h expected=none", wrap_mem_addr);
        end else begin
          checkOutput("wrap fetch address", 64'(wrap_mem_addr), 64'(exp_wrap_addrs.pop_front()));
        end
      end
      rd_prev      = mem_rd;
      wrap_rd_prev = wrap_mem_rd;
    end
  end

  // Runaway guard
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin : stimulus
    int          cycles;
    int          busy_count;
    int          end_count;
    int          rd_high;
    logic [9:0]  frame_exp;
    logic [39:0] line_seen;
    logic [39:0] line_exp;

    for (int i = 0; i < 65536; i++) dram[i] = 8'(i * 7 + 3);
    dram[16'h0010] = 8'hA5;
    dram[16'h0011] = 8'h3C;
    dram[16'h0012] = 8'hFF;
    dram[16'hFFFF] = 8'h5A;
    dram[16'h0000] = 8'hC3;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset data_to_pc", 64'(data_to_pc), 64'd1);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset mem_rd", 64'(mem_rd), 64'd0);
    checkOutput("reset end_transmitting", 64'(end_transmitting), 64'd0);
    checkOutput("reset mem_addr", 64'(mem_addr), 64'h0010);
    checkOutput("reset wrap mem_addr", 64'(wrap_mem_addr), 64'hFFFF);
    checkOutput("reset wrap data_to_pc", 64'(wrap_data_to_pc), 64'd1);
    @(posedge clock);
    #1;
    rst = 1'b0;

    // Three bytes with begin_transmit held; DONE holds while the level stays high
    pushMainTransfer(8'hA5, 8'h3C, 8'hFF);
    applyStimulus(1'b1);
    @(posedge clock);
    @(negedge clock);
    checkOutput("first cycle busy", 64'(busy), 64'd1);
    checkOutput("first cycle mem_rd", 64'(mem_rd), 64'd1);
    waitBusyLow(cycles);
    checkOutput("transfer length held", 64'(cycles), 64'd126);
    checkOutput("end_transmitting at done", 64'(end_transmitting), 64'd1);
    busy_count = 0;
    end_count  = 0;
    repeat (100) begin
      @(negedge clock);
      if (busy || mem_rd) busy_count++;
      if (end_transmitting) end_count++;
    end
    checkOutput("no retrigger in done", 64'(busy_count), 64'd0);
    checkOutput("end held in done", 64'(end_count), 64'd100);
    checkOutput("bytes outstanding", 64'(exp_bytes.size()), 64'd0);
    checkOutput("fetches outstanding", 64'(exp_addrs.size()), 64'd0);
    applyStimulus(1'b0);
    @(posedge clock);
    @(negedge clock);
    checkOutput("end after release", 64'(end_transmitting), 64'd0);

    // Second full transfer after release and re-raise
    pushMainTransfer(8'hA5, 8'h3C, 8'hFF);
    applyStimulus(1'b1);
    @(posedge clock);
    @(negedge clock);
    checkOutput("retrigger busy", 64'(busy), 64'd1);
    waitBusyLow(cycles);
    checkOutput("transfer length retrigger", 64'(cycles), 64'd126);
    checkOutput("end_transmitting retrigger", 64'(end_transmitting), 64'd1);
    applyStimulus(1'b0);
    @(posedge clock);
    @(negedge clock);
    checkOutput("end after second release", 64'(end_transmitting), 64'd0);

    // Exact waveform of byte 8'h01, begin_transmit dropped mid first byte
    dram[16'h0010] = 8'h01;
    pushMainTransfer(8'h01, 8'h3C, 8'hFF);
    frame_exp = {1'b1, 8'h01, 1'b0};
    for (int i = 0; i < 40; i++) line_exp[i] = frame_exp[i/4];
    line_seen = '0;
    rd_high   = 0;
    applyStimulus(1'b1);
    @(posedge clock);
    for (int j = 0; j < RL + 40; j++) begin
      @(negedge clock);
      if (j < RL) begin
        if (mem_rd) rd_high++;
      end else begin
        line_seen[j-RL] = data_to_pc;
      end
      if (j == RL) checkOutput("mem_rd after fetch", 64'(mem_rd), 64'd0);
      if (j == 10) begin_transmit = 1'b0;
    end
    checkOutput("mem_rd fetch width", 64'(rd_high), 64'd2);
    checkOutput("byte 01 waveform", 64'(line_seen), 64'(line_exp));
    waitBusyLow(cycles);
    checkOutput("transfer length dropped", 64'(cycles + RL + 39), 64'd126);
    end_count = 0;
    repeat (20) begin
      if (end_transmitting || busy) end_count++;
      @(negedge clock);
    end
    checkOutput("no end after drop", 64'(end_count), 64'd0);
    checkOutput("dropped bytes outstanding", 64'(exp_bytes.size()), 64'd0);
    dram[16'h0010] = 8'hA5;

    // Reset during bit 3 of the second byte
    dram[16'h0011] = 8'h00;
    pushMainTransfer(8'hA5, 8'h00, 8'hFF);
    applyStimulus(1'b1);
    @(posedge clock);
    @(negedge clock);
    repeat (61) @(posedge clock);
    #1;
    rst = 1'b1;
    @(negedge clock);
    checkOutput("line low before reset", 64'(data_to_pc), 64'd0);
    @(negedge clock);
    checkOutput("reset mid-byte data_to_pc", 64'(data_to_pc), 64'd1);
    checkOutput("reset mid-byte busy", 64'(busy), 64'd0);
    checkOutput("reset mid-byte mem_addr", 64'(mem_addr), 64'h0010);
    checkOutput("reset mid-byte mem_rd", 64'(mem_rd), 64'd0);
    exp_bytes.delete();
    exp_addrs.delete();
    @(posedge clock);
    #1;
    rst            = 1'b0;
    begin_transmit = 1'b0;
    dram[16'h0011] = 8'h3C;
    repeat (3) @(negedge clock);
    checkOutput("idle after reset", 64'(busy), 64'd0);
    pushMainTransfer(8'hA5, 8'h3C, 8'hFF);
    applyStimulus(1'b1);
    @(posedge clock);
    @(negedge clock);
    checkOutput("restart mem_addr", 64'(mem_addr), 64'h0010);
    waitBusyLow(cycles);
    checkOutput("transfer length restart", 64'(cycles), 64'd126);
    checkOutput("end_transmitting restart", 64'(end_transmitting), 64'd1);
    checkOutput("restart bytes outstanding", 64'(exp_bytes.size()), 64'd0);
    applyStimulus(1'b0);

    // Address wrap from FFFF to 0000
    exp_wrap_addrs.push_back(16'hFFFF);
    exp_wrap_addrs.push_back(16'h0000);
    @(posedge clock);
    #1;
    wrap_begin = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("wrap first address", 64'(wrap_mem_addr), 64'hFFFF);
    cycles = 0;
    while (wrap_busy && cycles < CYCLE_LIMIT) begin
      @(negedge clock);
      cycles++;
    end
    checkOutput("wrap transfer length", 64'(cycles), 64'd84);
    checkOutput("wrap end_transmitting", 64'(wrap_end), 64'd1);
    checkOutput("wrap line idle", 64'(wrap_data_to_pc), 64'd1);
    checkOutput("wrap fetches outstanding", 64'(exp_wrap_addrs.size()), 64'd0);
    @(posedge clock);
    #1;
    wrap_begin = 1'b0;

    repeat (5) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
